// File: rtl/rf_alu_ctrl.sv
// rf_alu_ctrl: three-state (IDLE/EXEC/WB) controller that decodes a 32-bit
// instruction. It drives register-file addresses and the ALU opcode, latches
// the ALU flags, and sequences the write-back for ALU, LI and CMP.
module rf_alu_ctrl #(
  parameter int ADDR = 4,
  parameter int SIZE = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [31:0]     inst_i,
  input  logic            inst_valid_i,
  output logic            inst_ready_o,
  input  logic            n_i,
  input  logic            z_i,
  input  logic            c_i,
  input  logic            v_i,
  output logic [ADDR-1:0] r_addr_a_o,
  output logic [ADDR-1:0] r_addr_b_o,
  output logic [ADDR-1:0] w_addr_o,
  output logic [3:0]      op_o,
  output logic            sco_o,
  output logic            cf_o,
  output logic            vf_o,
  output logic            write_reg_o,
  output logic            write_select_o,
  output logic [SIZE-1:0] input_data_o,
  output logic [3:0]      flags_o,
  output logic            done_o,
  output logic            err_o
);

  localparam logic [3:0] CLS_ALU = 4'b0000;
  localparam logic [3:0] CLS_LI  = 4'b0001;
  localparam logic [3:0] CLS_CMP = 4'b0010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] inst_q, inst_d;
  logic [3:0]  flags_q, flags_d;

  logic [3:0]  cls;
  logic        is_alu, is_li, is_cmp, is_illegal;

  assign cls        = inst_q[31:28];
  assign is_alu     = (cls == CLS_ALU);
  assign is_li      = (cls == CLS_LI);
  assign is_cmp     = (cls == CLS_CMP);
  assign is_illegal = !(is_alu || is_li || is_cmp);

  // The datapath-facing fields come straight from the latched instruction.
  // They therefore hold through EXEC and WB, and keep their last value in IDLE.
  assign r_addr_a_o   = ADDR'(inst_q[19:16]);
  assign r_addr_b_o   = ADDR'(inst_q[15:12]);
  assign w_addr_o     = ADDR'(inst_q[23:20]);
  assign op_o         = inst_q[27:24];
  assign sco_o        = inst_q[11];
  assign input_data_o = {{(SIZE-16){1'b0}}, inst_q[15:0]};
  assign flags_o      = flags_q;
  assign cf_o         = flags_q[1];
  assign vf_o         = flags_q[0];

  // State register: a reset aborts any instruction in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Instruction and flag registers: capture on the handshake, and take flags when EXEC ends.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inst_q  <= '0;
      flags_q <= '0;
    end else begin
      inst_q  <= inst_d;
      flags_q <= flags_d;
    end
  end

  // Next-state and register-load logic for the IDLE -> EXEC -> WB sequence.
  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    flags_d = flags_q;
    case (state_q)
      IDLE: begin
        if (inst_valid_i) begin
          inst_d  = inst_i;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (is_alu || is_cmp) begin
          flags_d = {n_i, z_i, c_i, v_i};
        end
        state_d = WB;
      end
      WB: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode: the write-back strobes are only active in WB; ready is only active in IDLE outside reset.
  always_comb begin
    inst_ready_o   = 1'b0;
    write_reg_o    = 1'b0;
    write_select_o = 1'b0;
    done_o         = 1'b0;
    err_o          = 1'b0;
    case (state_q)
      IDLE: begin
        inst_ready_o = !rst_i;
      end
      WB: begin
        write_reg_o    = is_alu || is_li;
        write_select_o = is_li;
        done_o         = 1'b1;
        err_o          = is_illegal;
      end
      default: begin
        inst_ready_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_rf_alu_ctrl.sv
// tb_rf_alu_ctrl: directed vectors with hand-computed expectations for rf_alu_ctrl.
module tb_rf_alu_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] inst;
  logic        instValid;
  logic        instReady;
  logic        n, z, c, v;
  logic [3:0]  rAddrA, rAddrB, wAddr;
  logic [3:0]  op;
  logic        sco, cf, vf;
  logic        writeReg, writeSelect;
  logic [31:0] inputData;
  logic [3:0]  flags;
  logic        done, err;

  int compared   = 0;
  int mismatched = 0;

  rf_alu_ctrl #(.ADDR(4), .SIZE(32)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .inst_i         (inst),
    .inst_valid_i   (instValid),
    .inst_ready_o   (instReady),
    .n_i            (n),
    .z_i            (z),
    .c_i            (c),
    .v_i            (v),
    .r_addr_a_o     (rAddrA),
    .r_addr_b_o     (rAddrB),
    .w_addr_o       (wAddr),
    .op_o           (op),
    .sco_o          (sco),
    .cf_o           (cf),
    .vf_o           (vf),
    .write_reg_o    (writeReg),
    .write_select_o (writeSelect),
    .input_data_o   (inputData),
    .flags_o        (flags),
    .done_o         (done),
    .err_o          (err)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] i, input logic valid, input logic [3:0] nzcv);
    inst      = i;
    instValid = valid;
    {n, z, c, v} = nzcv;
  endtask

  // Advance to just after the next rising edge.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  int lastDone;
  int doneCount;
  int accIdx;
  logic [31:0] heldInst [3];

  initial begin
    rst = 1'b1;
    applyStimulus(32'h0, 1'b0, 4'b0000);
    stepCycle();
    stepCycle();

    // Reset state.
    checkOutput("rst_ready", 32'(instReady), 32'h0);
    checkOutput("rst_flags", 32'(flags), 32'h0);
    checkOutput("rst_wreg", 32'(writeReg), 32'h0);
    checkOutput("rst_waddr", 32'(wAddr), 32'h0);
    checkOutput("rst_idata", inputData, 32'h0);
    checkOutput("rst_done", 32'(done), 32'h0);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_ready", 32'(instReady), 32'h1);

    // LI r3 <- 0xA5
    applyStimulus(32'h103000A5, 1'b1, 4'b1111);
    stepCycle();
    instValid = 1'b0;
    checkOutput("li_exec_ready", 32'(instReady), 32'h0);
    checkOutput("li_exec_wreg", 32'(writeReg), 32'h0);
    stepCycle();
    checkOutput("li_wb_wreg", 32'(writeReg), 32'h1);
    checkOutput("li_wb_wsel", 32'(writeSelect), 32'h1);
    checkOutput("li_wb_waddr", 32'(wAddr), 32'h3);
    checkOutput("li_wb_idata", inputData, 32'h000000A5);
    checkOutput("li_wb_done", 32'(done), 32'h1);
    checkOutput("li_wb_flags", 32'(flags), 32'h0);
    stepCycle();
    checkOutput("li_idle_ready", 32'(instReady), 32'h1);
    checkOutput("li_idle_done", 32'(done), 32'h0);
    checkOutput("li_idle_wreg", 32'(writeReg), 32'h0);
    checkOutput("li_idle_waddr_hold", 32'(wAddr), 32'h3);
    checkOutput("li_idle_idata_hold", inputData, 32'h000000A5);

    // ALU r5 <- r1 op2 r2, flags 0010
    applyStimulus(32'h02512000, 1'b1, 4'b0010);
    stepCycle();
    instValid = 1'b0;
    checkOutput("alu_exec_ra", 32'(rAddrA), 32'h1);
    checkOutput("alu_exec_rb", 32'(rAddrB), 32'h2);
    checkOutput("alu_exec_op", 32'(op), 32'h2);
    checkOutput("alu_exec_sco", 32'(sco), 32'h0);
    stepCycle();
    checkOutput("alu_wb_wreg", 32'(writeReg), 32'h1);
    checkOutput("alu_wb_wsel", 32'(writeSelect), 32'h0);
    checkOutput("alu_wb_waddr", 32'(wAddr), 32'h5);
    checkOutput("alu_wb_flags", 32'(flags), 32'h2);
    checkOutput("alu_wb_err", 32'(err), 32'h0);
    stepCycle();

    // CMP with flags 0111, followed by an ALU with SC=1
    applyStimulus(32'h23000000, 1'b1, 4'b0111);
    stepCycle();
    instValid = 1'b0;
    stepCycle();
    checkOutput("cmp_wb_wreg", 32'(writeReg), 32'h0);
    checkOutput("cmp_wb_done", 32'(done), 32'h1);
    checkOutput("cmp_wb_flags", 32'(flags), 32'h7);
    stepCycle();
    applyStimulus(32'h01435800, 1'b1, 4'b1000);
    stepCycle();
    instValid = 1'b0;
    checkOutput("alu2_exec_cf", 32'(cf), 32'h1);
    checkOutput("alu2_exec_vf", 32'(vf), 32'h1);
    checkOutput("alu2_exec_sco", 32'(sco), 32'h1);
    checkOutput("alu2_exec_ra", 32'(rAddrA), 32'h3);
    checkOutput("alu2_exec_rb", 32'(rAddrB), 32'h5);
    checkOutput("alu2_exec_op", 32'(op), 32'h1);
    stepCycle();
    checkOutput("alu2_wb_flags", 32'(flags), 32'h8);
    checkOutput("alu2_wb_waddr", 32'(wAddr), 32'h4);
    checkOutput("alu2_wb_wreg", 32'(writeReg), 32'h1);
    stepCycle();

    // Illegal class F
    applyStimulus(32'hF0000000, 1'b1, 4'b1111);
    stepCycle();
    instValid = 1'b0;
    stepCycle();
    checkOutput("ill_wb_err", 32'(err), 32'h1);
    checkOutput("ill_wb_done", 32'(done), 32'h1);
    checkOutput("ill_wb_wreg", 32'(writeReg), 32'h0);
    checkOutput("ill_wb_flags", 32'(flags), 32'h8);
    stepCycle();
    checkOutput("ill_idle_err", 32'(err), 32'h0);

    // Reset during the WB of an ALU instruction
    applyStimulus(32'h07612000, 1'b1, 4'b0101);
    stepCycle();
    instValid = 1'b0;
    stepCycle();
    checkOutput("rmid_wb_wreg", 32'(writeReg), 32'h1);
    checkOutput("rmid_wb_flags", 32'(flags), 32'h5);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rmid_wreg", 32'(writeReg), 32'h0);
    checkOutput("rmid_flags", 32'(flags), 32'h0);
    checkOutput("rmid_done", 32'(done), 32'h0);
    checkOutput("rmid_waddr", 32'(wAddr), 32'h0);
    checkOutput("rmid_ready", 32'(instReady), 32'h0);
    stepCycle();
    rst = 1'b0;
    #1;
    checkOutput("rmid_rel_ready", 32'(instReady), 32'h1);
    applyStimulus(32'h10901234, 1'b1, 4'b0000);
    stepCycle();
    instValid = 1'b0;
    stepCycle();
    checkOutput("rmid_li_wreg", 32'(writeReg), 32'h1);
    checkOutput("rmid_li_waddr", 32'(wAddr), 32'h9);
    checkOutput("rmid_li_idata", inputData, 32'h00001234);
    stepCycle();

    // Held valid: three LIs in sequence, valid never dropping between them
    heldInst[0] = 32'h10100011;
    heldInst[1] = 32'h10200022;
    heldInst[2] = 32'h10300033;
    doneCount = 0;
    accIdx    = 0;
    lastDone  = -1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (done) begin
        if (doneCount < 3) begin
          checkOutput("held_waddr", 32'(wAddr), 32'(doneCount + 1));
          checkOutput("held_idata", inputData, 32'((doneCount + 1) * 32'h11));
        end
        if (lastDone >= 0) begin
          checkOutput("held_spacing", 32'(cyc - lastDone), 32'd3);
        end
        lastDone = cyc;
        doneCount++;
      end
      if (instReady) begin
        if (accIdx < 3) begin
          applyStimulus(heldInst[accIdx], 1'b1, 4'b0000);
          accIdx++;
        end else begin
          instValid = 1'b0;
        end
      end
      stepCycle();
    end
    checkOutput("held_done_count", 32'(doneCount), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
